// File: rtl/ex_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: shift-add multiply, restoring divide.
// Optional MADD/MSUB accumulate ops are compiled in with `define MULDIV_MADD_EN.
module ex_muldiv_iter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic [DATA_W-1:0] acc_hi_i,
  input  logic [DATA_W-1:0] acc_lo_i,
  input  logic              cancel_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              dz_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] h_q, h_d;
  logic [DATA_W-1:0] l_q, l_d;
  logic              div_q, div_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;

  logic              op_legal, op_signed, op_div, sgn_a, sgn_b, dz, accept;
  logic [DATA_W-1:0] mag_a, mag_b;

  // Request decode; stall is combinational so the pipeline holds in the start cycle.
  always_comb begin
    op_signed = ~op_i[0];
    op_div    = (op_i == 3'd2) | (op_i == 3'd3);
`ifdef MULDIV_MADD_EN
    op_legal  = 1'b1;
`else
    op_legal  = ~op_i[2];
`endif
    sgn_a   = op_signed & opa_i[DATA_W-1];
    sgn_b   = op_signed & opb_i[DATA_W-1];
    mag_a   = sgn_a ? -opa_i : opa_i;
    mag_b   = sgn_b ? -opb_i : opb_i;
    dz      = op_div & (opb_i == '0);
    accept  = start_i & ~cancel_i & (state_q != S_BUSY) & op_legal;
    stall_o = (state_q == S_BUSY) | (accept & ~dz);
  end

`ifdef MULDIV_MADD_EN
  logic          madd_q, madd_d;
  logic          msub_q, msub_d;
  logic [PW-1:0] acc_q, acc_d;

  always_comb begin
    madd_d = madd_q;
    msub_d = msub_q;
    acc_d  = acc_q;
    if (accept && !dz) begin
      madd_d = op_i[2];
      msub_d = op_i[2] & op_i[1];
      acc_d  = {acc_hi_i, acc_lo_i};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      madd_q <= 1'b0;
      msub_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      madd_q <= madd_d;
      msub_q <= msub_d;
      acc_q  <= acc_d;
    end
  end
`else
  logic unused_acc;
  assign unused_acc = ^{acc_hi_i, acc_lo_i};
`endif

  logic [DATA_W:0]   mul_sum, div_sh, div_sub;
  logic              div_ge;
  logic [DATA_W-1:0] it_h, it_l, fin_hi, fin_lo;
  logic [PW-1:0]     prod_s, res;

  // One iteration step plus the sign/accumulate fix-up used on the last step.
  always_comb begin
    mul_sum = {1'b0, h_q} + (l_q[0] ? {1'b0, a_q} : '0);
    div_sh  = {h_q, l_q[DATA_W-1]};
    div_ge  = div_sh >= {1'b0, a_q};
    div_sub = div_sh - {1'b0, a_q};
    if (div_q) begin
      it_h = div_ge ? div_sub[DATA_W-1:0] : div_sh[DATA_W-1:0];
      it_l = {l_q[DATA_W-2:0], div_ge};
    end else begin
      it_h = mul_sum[DATA_W:1];
      it_l = {mul_sum[0], l_q[DATA_W-1:1]};
    end
    prod_s = neg_q ? -{it_h, it_l} : {it_h, it_l};
    res    = prod_s;
`ifdef MULDIV_MADD_EN
    if (madd_q) res = msub_q ? (acc_q - prod_s) : (acc_q + prod_s);
`endif
    fin_hi = div_q ? (rneg_q ? -it_h : it_h) : res[PW-1:DATA_W];
    fin_lo = div_q ? (neg_q ? -it_l : it_l) : res[DATA_W-1:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    h_d     = h_q;
    l_d     = l_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    if (cancel_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_BUSY) begin
      h_d   = it_h;
      l_d   = it_l;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        state_d = S_DONE;
        cnt_d   = '0;
        done_d  = 1'b1;
        hi_d    = fin_hi;
        lo_d    = fin_lo;
      end
    end else begin
      state_d = S_IDLE;
      if (accept && dz) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        dz_d    = 1'b1;
        hi_d    = opa_i;
        lo_d    = '1;
      end else if (accept) begin
        state_d = S_BUSY;
        cnt_d   = '0;
        div_d   = op_div;
        neg_d   = sgn_a ^ sgn_b;
        rneg_d  = sgn_a;
        h_d     = '0;
        a_d     = op_div ? mag_b : mag_a;
        l_d     = op_div ? mag_a : mag_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      h_q     <= '0;
      l_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      h_q     <= h_d;
      l_q     <= l_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o = (state_q == S_BUSY);
  assign done_o = done_q;
  assign dz_o   = dz_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Bench for ex_muldiv_iter: arithmetic reference model with per-cycle compare plus directed literals.
module tb_ex_muldiv_iter;
  localparam int unsigned DW = 32;

  logic          clk, rst, start_i, cancel_i;
  logic [2:0]    op_i;
  logic [DW-1:0] opa_i, opb_i, acc_hi_i, acc_lo_i;
  logic          stall_o, busy_o, done_o, dz_o;
  logic [DW-1:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  ex_muldiv_iter #(.DATA_W(DW), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opa_i(opa_i), .opb_i(opb_i),
    .acc_hi_i(acc_hi_i), .acc_lo_i(acc_lo_i), .cancel_i(cancel_i), .stall_o(stall_o),
    .busy_o(busy_o), .done_o(done_o), .dz_o(dz_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return op < 3'd4;
`endif
  endfunction

  // Reference result {dz, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, p, q, r;
    if (op[0] == 1'b0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    if (op == 3'd2 || op == 3'd3) begin
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    p = sa * sb;
    if (op >= 3'd6) p = longint'(acc) - p;
    else if (op >= 3'd4) p = longint'(acc) + p;
    return {1'b0, p};
  endfunction

  // Model state: one pending result with the cycle index its done pulse is due.
  bit          pend = 1'b0, pdz = 1'b0;
  int          cyc = 0, due = 0;
  logic [31:0] phi = '0, plo = '0, last_hi = '0, last_lo = '0;

  initial begin
    logic [64:0] r;
    bit busy_m;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        pend = 1'b0; cyc = 0; last_hi = '0; last_lo = '0;
      end else begin
        busy_m = pend && !pdz && (cyc < due);
        if (cancel_i && pend && cyc < due) pend = 1'b0;
        cyc++;
        if (start_i && !cancel_i && !busy_m && legal(op_i)) begin
          r    = model_res(op_i, opa_i, opb_i, {acc_hi_i, acc_lo_i});
          pend = 1'b1;
          pdz  = r[64];
          phi  = r[63:32];
          plo  = r[31:0];
          due  = cyc + (pdz ? 0 : 32);
        end
      end
    end
  end

  // Per-cycle compare against the model, mid-cycle.
  initial begin
    bit busy_e, done_e, dz_in, stall_e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_e  = pend && !pdz && (cyc < due);
        done_e  = pend && (cyc == due);
        dz_in   = (op_i == 3'd2 || op_i == 3'd3) && (opb_i == 32'd0);
        stall_e = busy_e || (start_i && !cancel_i && legal(op_i) && !dz_in);
        chk("cyc done", 64'(done_o), 64'(done_e));
        chk("cyc busy", 64'(busy_o), 64'(busy_e));
        chk("cyc stall", 64'(stall_o), 64'(stall_e));
        if (done_e) begin
          chk("cyc hi", 64'(hi_o), 64'(phi));
          chk("cyc lo", 64'(lo_o), 64'(plo));
          chk("cyc dz", 64'(dz_o), 64'(pdz));
          last_hi = phi;
          last_lo = plo;
          pend    = 1'b0;
        end else begin
          chk("cyc hold hi", 64'(hi_o), 64'(last_hi));
          chk("cyc hold lo", 64'(lo_o), 64'(last_lo));
          chk("cyc dz low", 64'(dz_o), 64'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from the current cycle and check hand-computed results and latency.
  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] acc, input logic [31:0] eh,
                     input logic [31:0] el, input logic edz);
    int lat;
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
    {acc_hi_i, acc_lo_i} = acc;
    step();
    start_i = 1'b0;
    lat = 0;
    while (!done_o && lat < 40) begin
      step();
      lat++;
    end
    chk({name, " latency"}, 64'(lat), edz ? 64'd0 : 64'd32);
    chk({name, " hi"}, 64'(hi_o), 64'(eh));
    chk({name, " lo"}, 64'(lo_o), 64'(el));
    chk({name, " dz"}, 64'(dz_o), 64'(edz));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start_i = 1'b0; cancel_i = 1'b0; op_i = '0;
    opa_i = '0; opb_i = '0; acc_hi_i = '0; acc_lo_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi", 64'(hi_o), 64'd0);
    chk("reset lo", 64'(lo_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    chk("reset dz", 64'(dz_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset stall", 64'(stall_o), 64'd0);
    rst = 1'b1;
    step();

    run("mult -2*3", 3'd0, 32'hFFFF_FFFE, 32'h3, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run("multu max*max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 32'hFFFF_FFFE, 32'h1, 1'b0);
    run("mult min*min", 3'd0, 32'h8000_0000, 32'h8000_0000, 64'd0, 32'h4000_0000, 32'h0, 1'b0);
    run("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'h2, 64'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("div 7/-2", 3'd2, 32'h7, 32'hFFFF_FFFE, 64'd0, 32'h1, 32'hFFFF_FFFD, 1'b0);
    run("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 32'h0, 32'h8000_0000, 1'b0);
    run("divu 100/7", 3'd3, 32'd100, 32'd7, 64'd0, 32'd2, 32'd14, 1'b0);
    run("div -16/0", 3'd2, 32'hFFFF_FFF0, 32'h0, 64'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
    run("divu 0x1234/0", 3'd3, 32'h1234, 32'h0, 64'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);

    // Cancel at iteration 10; prior results must hold and a fresh start must complete.
    start_i = 1'b1; op_i = 3'd1; opa_i = 32'd5; opb_i = 32'd7;
    step();
    start_i = 1'b0;
    repeat (9) step();
    cancel_i = 1'b1;
    step();
    cancel_i = 1'b0;
    chk("cancel busy", 64'(busy_o), 64'd0);
    chk("cancel hi kept", 64'(hi_o), 64'h1234);
    chk("cancel lo kept", 64'(lo_o), 64'hFFFF_FFFF);
    run("multu 5*7 after cancel", 3'd1, 32'd5, 32'd7, 64'd0, 32'd0, 32'd35, 1'b0);

    // Simultaneous start and cancel: start is dropped.
    start_i = 1'b1; cancel_i = 1'b1; op_i = 3'd0; opa_i = 32'd3; opb_i = 32'd3;
    step();
    start_i = 1'b0; cancel_i = 1'b0;
    chk("start+cancel busy", 64'(busy_o), 64'd0);
    repeat (34) step();
    chk("start+cancel lo kept", 64'(lo_o), 64'd35);

`ifdef MULDIV_MADD_EN
    run("madd 16+(-1*4)", 3'd4, 32'hFFFF_FFFF, 32'd4, 64'h10, 32'h0, 32'hC, 1'b0);
    run("msubu 0-1*1", 3'd7, 32'd1, 32'd1, 64'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`else
    start_i = 1'b1; op_i = 3'd4; opa_i = 32'hFFFF_FFFF; opb_i = 32'd4;
    {acc_hi_i, acc_lo_i} = 64'h10;
    #1;
    chk("madd illegal stall", 64'(stall_o), 64'd0);
    step();
    start_i = 1'b0;
    chk("madd illegal busy", 64'(busy_o), 64'd0);
    repeat (34) step();
    chk("madd illegal lo kept", 64'(lo_o), 64'd35);
`endif

    // Asynchronous reset mid-operation clears everything at once.
    start_i = 1'b1; op_i = 3'd1; opa_i = 32'd9; opb_i = 32'd9;
    step();
    start_i = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    #1;
    chk("midrst hi", 64'(hi_o), 64'd0);
    chk("midrst lo", 64'(lo_o), 64'd0);
    chk("midrst done", 64'(done_o), 64'd0);
    chk("midrst dz", 64'(dz_o), 64'd0);
    chk("midrst busy", 64'(busy_o), 64'd0);
    chk("midrst stall", 64'(stall_o), 64'd0);
    step();
    rst = 1'b1;
    step();
    run("multu 6*7 after reset", 3'd1, 32'd6, 32'd7, 64'd0, 32'd0, 32'd42, 1'b0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
